// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: branch and FSM encodings plus the reset / exception vectors shared by the fetch sequencer.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        BR_SEQ = 2'b00,
        BR_BEQ = 2'b01,
        BR_J   = 2'b10,
        BR_JR  = 2'b11
    } branch_t;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: hazard, ID-stage branch and instruction-memory signals around the PC sequencer.
// Exception ports exist only when PC_SEQ_EXC_EN is defined.
interface pc_sequencer_if;

    logic        i_stall;
    logic        i_redirect;
    logic [1:0]  i_branch;
    logic        i_Zero;
    logic [25:0] i_jal_addr;
    logic [31:0] i_jr_addr;
    logic [31:0] i_offset;
    logic        i_im_ready;
    logic        o_im_req;
    logic [31:0] o_PC;
    logic [31:0] o_PC4;
    logic        o_if_valid;
    logic [31:0] o_fetch_cnt;
`ifdef PC_SEQ_EXC_EN
    logic        i_exc;
    logic        i_eret;
    logic [31:0] i_epc;
    logic        o_adel;
`endif

    modport master (
        input  i_stall, i_redirect, i_branch, i_Zero, i_jal_addr, i_jr_addr, i_offset, i_im_ready,
        output o_im_req, o_PC, o_PC4, o_if_valid, o_fetch_cnt
`ifdef PC_SEQ_EXC_EN
        , input i_exc, i_eret, i_epc
        , output o_adel
`endif
    );

    modport slave (
        output i_stall, i_redirect, i_branch, i_Zero, i_jal_addr, i_jr_addr, i_offset, i_im_ready,
        input  o_im_req, o_PC, o_PC4, o_if_valid, o_fetch_cnt
`ifdef PC_SEQ_EXC_EN
        , output i_exc, i_eret, i_epc
        , input  o_adel
`endif
    );

endinterface

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational next-PC mux; targets are relative to the branch in ID (pc - 4).
// Without PC_SEQ_EXC_EN the jr target is forced word-aligned.
module pc_target_calc
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        redirect,
    input  logic [1:0]  branch,
    input  logic        zero,
    input  logic [25:0] jal_addr,
    input  logic [31:0] jr_addr,
    input  logic [31:0] offset,
    output logic [31:0] next_pc,
    output logic        take
);

    logic [31:0] pc_id;
    logic [31:0] jr_tgt;
    logic [31:0] br_tgt;

`ifdef PC_SEQ_EXC_EN
    assign jr_tgt = jr_addr;
`else
    assign jr_tgt = jr_addr & ~32'd3;
`endif

    always_comb begin
        pc_id   = pc - 32'd4;
        take    = redirect && (branch == BR_J || branch == BR_JR || (branch == BR_BEQ && zero));
        br_tgt  = branch == BR_BEQ ? pc_id + 32'd4 + (offset << 2)
                : branch == BR_J   ? ((pc_id + 32'd4) & 32'hF000_0000) | {4'b0, jal_addr, 2'b00}
                : jr_tgt;
        next_pc = take ? br_tgt : pc + 32'd4;
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: architectural PC register, fetch FSM, pending-redirect register and fetch counter.
// Optional exception entry/return and misaligned-jr detection are enabled by PC_SEQ_EXC_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = pc_sequencer_pkg::RESET_PC
`ifdef PC_SEQ_EXC_EN
    , parameter logic [31:0] EXC_VEC = pc_sequencer_pkg::EXC_VEC
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    pc_sequencer_if.master        bus
);

    import pc_sequencer_pkg::*;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc;
    logic [31:0] pend;
    logic [31:0] cnt;
    logic [31:0] calc_pc;
    logic [31:0] seq_pc;
    logic [31:0] ovr_pc;
    logic        pend_v;
    logic        take;
    logic        accept;
    logic        latch;
    logic        ovr;

    pc_target_calc u_calc (
        .pc       (pc),
        .redirect (bus.i_redirect),
        .branch   (bus.i_branch),
        .zero     (bus.i_Zero),
        .jal_addr (bus.i_jal_addr),
        .jr_addr  (bus.i_jr_addr),
        .offset   (bus.i_offset),
        .next_pc  (calc_pc),
        .take     (take)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= ST_BOOT;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state == ST_BOOT ? ST_FETCH
                 : bus.i_stall     ? state
                 : bus.i_im_ready  ? ST_FETCH
                 : ST_WAIT;
    end

    always_comb begin
        bus.o_im_req = state != ST_BOOT;
    end

    // A redirect seen while memory is not ready is parked until the next accepted fetch.
    assign accept = bus.o_im_req & bus.i_im_ready & ~bus.i_stall;
    assign latch  = bus.o_im_req & ~bus.i_im_ready & ~bus.i_stall & take;
    assign seq_pc = (take || !pend_v) ? calc_pc : pend;

`ifdef PC_SEQ_EXC_EN
    logic adel_hit;
    logic adel;

    assign adel_hit = bus.o_im_req & ~bus.i_stall & take & (bus.i_branch == BR_JR) & (|calc_pc[1:0]);
    assign ovr      = bus.i_exc | bus.i_eret | adel_hit;
    assign ovr_pc   = bus.i_exc ? EXC_VEC : bus.i_eret ? bus.i_epc : EXC_VEC;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            adel <= 1'b0;
        else
            adel <= adel_hit;
    end

    assign bus.o_adel = adel;
`else
    assign ovr    = 1'b0;
    assign ovr_pc = RESET_PC;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc     <= RESET_PC;
            pend   <= '0;
            pend_v <= 1'b0;
            cnt    <= '0;
        end else begin
            if (ovr) begin
                pc     <= ovr_pc;
                pend_v <= 1'b0;
            end else if (accept) begin
                pc     <= seq_pc;
                pend_v <= 1'b0;
            end else if (latch) begin
                pend   <= calc_pc;
                pend_v <= 1'b1;
            end
            if (accept)
                cnt <= cnt + 32'd1;
        end
    end

    assign bus.o_PC        = pc;
    assign bus.o_PC4       = pc + 32'd4;
    assign bus.o_if_valid  = accept;
    assign bus.o_fetch_cnt = cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven vectors plus hand-written stall / wait-state / exception sequences.
module tb_pc_sequencer;

    typedef struct {
        logic        st;
        logic        rd;
        logic [1:0]  br;
        logic        z;
        logic [25:0] jal;
        logic [31:0] jr;
        logic [31:0] off;
        logic        rdy;
        logic [31:0] pc;
        logic        v;
        logic [31:0] cnt;
        logic        req;
    } vec_t;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b1;
    int   n_total = 0;
    int   n_pass = 0;
    vec_t tbl[$];

    pc_sequencer_if bus();

    pc_sequencer dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    function automatic vec_t mk(logic st, logic rd, logic [1:0] br, logic z, logic [25:0] jal,
                                logic [31:0] jr, logic [31:0] off, logic rdy,
                                logic [31:0] pc, logic v, logic [31:0] cnt, logic req);
        vec_t r;
        r.st = st; r.rd = rd; r.br = br; r.z = z; r.jal = jal; r.jr = jr; r.off = off; r.rdy = rdy;
        r.pc = pc; r.v = v; r.cnt = cnt; r.req = req;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    // Drive one cycle's inputs just after a falling edge, check, then advance to the next falling edge.
    task automatic run(string tag, vec_t r);
        bus.i_stall    = r.st;
        bus.i_redirect = r.rd;
        bus.i_branch   = r.br;
        bus.i_Zero     = r.z;
        bus.i_jal_addr = r.jal;
        bus.i_jr_addr  = r.jr;
        bus.i_offset   = r.off;
        bus.i_im_ready = r.rdy;
        #1;
        chk({tag, " pc"}, bus.o_PC, r.pc);
        chk({tag, " pc4"}, bus.o_PC4, r.pc + 32'd4);
        chk({tag, " valid"}, {31'b0, bus.o_if_valid}, {31'b0, r.v});
        chk({tag, " cnt"}, bus.o_fetch_cnt, r.cnt);
        chk({tag, " req"}, {31'b0, bus.o_im_req}, {31'b0, r.req});
        @(negedge i_clk);
    endtask

    function automatic vec_t d(logic [31:0] pc, logic v, logic [31:0] cnt);
        return mk(0, 0, 2'b00, 0, 26'h0, 32'h0, 32'h0, 1, pc, v, cnt, 1);
    endfunction

    initial begin
        bus.i_stall = 0; bus.i_redirect = 0; bus.i_branch = 0; bus.i_Zero = 0;
        bus.i_jal_addr = 0; bus.i_jr_addr = 0; bus.i_offset = 0; bus.i_im_ready = 1;
`ifdef PC_SEQ_EXC_EN
        bus.i_exc = 0; bus.i_eret = 0; bus.i_epc = 0;
`endif
        tbl.push_back(mk(0, 0, 2'b00, 0, 26'h0,     32'h0,         32'h0,         1, 32'h0000_3000, 0, 0,  0));
        tbl.push_back(d(32'h0000_3000, 1, 0));
        tbl.push_back(d(32'h0000_3004, 1, 1));
        tbl.push_back(d(32'h0000_3008, 1, 2));
        tbl.push_back(mk(0, 1, 2'b01, 1, 26'h0,     32'h0,         32'h3,         1, 32'h0000_300C, 1, 3,  1));
        tbl.push_back(mk(0, 1, 2'b11, 0, 26'h0,     32'h0000_300C, 32'h0,         1, 32'h0000_3018, 1, 4,  1));
        tbl.push_back(mk(0, 1, 2'b01, 0, 26'h0,     32'h0,         32'h3,         1, 32'h0000_300C, 1, 5,  1));
        tbl.push_back(mk(0, 1, 2'b11, 0, 26'h0,     32'h0000_3004, 32'h0,         1, 32'h0000_3010, 1, 6,  1));
        tbl.push_back(mk(0, 1, 2'b10, 0, 26'h0C10,  32'h0,         32'h0,         1, 32'h0000_3004, 1, 7,  1));
        tbl.push_back(mk(0, 1, 2'b11, 0, 26'h0,     32'h0000_3100, 32'h0,         1, 32'h0000_3040, 1, 8,  1));
        tbl.push_back(mk(0, 0, 2'b10, 0, 26'h0C10,  32'h0,         32'h0,         1, 32'h0000_3100, 1, 9,  1));
        tbl.push_back(mk(0, 1, 2'b00, 0, 26'h0,     32'h0,         32'h0,         1, 32'h0000_3104, 1, 10, 1));
        tbl.push_back(mk(0, 1, 2'b11, 0, 26'h0,     32'hFFFF_FFFC, 32'h0,         1, 32'h0000_3108, 1, 11, 1));
        tbl.push_back(d(32'hFFFF_FFFC, 1, 12));
        tbl.push_back(mk(0, 1, 2'b01, 1, 26'h0,     32'h0,         32'hFFFF_FFFE, 1, 32'h0000_0000, 1, 13, 1));
        tbl.push_back(mk(0, 1, 2'b10, 0, 26'h400,   32'h0,         32'h0,         1, 32'hFFFF_FFF8, 1, 14, 1));
        tbl.push_back(mk(0, 1, 2'b11, 0, 26'h0,     32'h0000_3000, 32'h0,         1, 32'hF000_1000, 1, 15, 1));
        tbl.push_back(d(32'h0000_3000, 1, 16));

        #2 i_rst_n = 1'b0;
        @(negedge i_clk);
        chk("reset pc", bus.o_PC, 32'h0000_3000);
        chk("reset cnt", bus.o_fetch_cnt, 32'h0);
        chk("reset req", {31'b0, bus.o_im_req}, 32'h0);
        chk("reset valid", {31'b0, bus.o_if_valid}, 32'h0);
`ifdef PC_SEQ_EXC_EN
        chk("reset adel", {31'b0, bus.o_adel}, 32'h0);
`endif
        i_rst_n = 1'b1;
        foreach (tbl[i]) run($sformatf("row%0d", i), tbl[i]);

        // Stall held across a redirect, redirect re-presented once the stall drops.
        for (int k = 0; k < 3; k++)
            run($sformatf("stall%0d", k), mk(1, 1, 2'b11, 0, 26'h0, 32'h0000_3200, 32'h0, 1, 32'h0000_3004, 0, 17, 1));
        run("stall_rel", mk(0, 1, 2'b11, 0, 26'h0, 32'h0000_3200, 32'h0, 1, 32'h0000_3004, 1, 17, 1));

        // Redirect during instruction-memory wait states.
        run("wait0", mk(0, 1, 2'b11, 0, 26'h0, 32'h0000_3300, 32'h0, 0, 32'h0000_3200, 0, 18, 1));
        run("wait1", mk(0, 0, 2'b00, 0, 26'h0, 32'h0,         32'h0, 0, 32'h0000_3200, 0, 18, 1));
        run("wait_acc", d(32'h0000_3200, 1, 18));
        run("wait_tgt", d(32'h0000_3300, 1, 19));
        run("ovw0", mk(0, 1, 2'b11, 0, 26'h0, 32'h0000_3400, 32'h0, 0, 32'h0000_3304, 0, 20, 1));
        run("ovw1", mk(0, 1, 2'b11, 0, 26'h0, 32'h0000_3500, 32'h0, 0, 32'h0000_3304, 0, 20, 1));
        run("ovw_acc", d(32'h0000_3304, 1, 20));
        run("ovw_tgt", d(32'h0000_3500, 1, 21));

`ifdef PC_SEQ_EXC_EN
        bus.i_exc = 1;
        run("exc_stall", mk(1, 0, 2'b00, 0, 26'h0, 32'h0, 32'h0, 1, 32'h0000_3504, 0, 22, 1));
        bus.i_exc = 0;
        run("exc_vec", d(32'h0000_4180, 1, 22));
        chk("adel idle", {31'b0, bus.o_adel}, 32'h0);
        run("adel_jr", mk(0, 1, 2'b11, 0, 26'h0, 32'h0000_3102, 32'h0, 1, 32'h0000_4184, 1, 23, 1));
        chk("adel pulse", {31'b0, bus.o_adel}, 32'h1);
        run("adel_vec", d(32'h0000_4180, 1, 24));
        chk("adel clear", {31'b0, bus.o_adel}, 32'h0);
        bus.i_eret = 1; bus.i_epc = 32'h0000_5000;
        run("eret", d(32'h0000_4184, 1, 25));
        bus.i_eret = 0;
        run("eret_pc", d(32'h0000_5000, 1, 26));
`else
        run("jr_mask", mk(0, 1, 2'b11, 0, 26'h0, 32'h0000_3103, 32'h0, 1, 32'h0000_3504, 1, 22, 1));
        run("jr_masked", d(32'h0000_3100, 1, 23));
`endif

        // Asynchronous reset while the FSM sits in WAIT.
        bus.i_im_ready = 0;
        @(negedge i_clk);
        chk("wait req", {31'b0, bus.o_im_req}, 32'h1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("async pc", bus.o_PC, 32'h0000_3000);
        chk("async cnt", bus.o_fetch_cnt, 32'h0);
        chk("async req", {31'b0, bus.o_im_req}, 32'h0);
        chk("async valid", {31'b0, bus.o_if_valid}, 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
